uart_cmd_ctrl: RTL and testbench
================================

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16'd52080: inter-byte timeout in clk cycles; 0 disables the timeout.
REQ-002 Parameter ACK_BYTE, default 8'hA5: response byte sent after a command is consumed.
REQ-003 Parameter NAK_BYTE, default 8'hEE: response byte sent after a frame timeout.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 rx_rdy  input  1  byte-available level from the UART receiver.
REQ-008 rx_data  input  8  received byte; valid while rx_rdy=1.
REQ-009 clr_rx_rdy  output  1  one-cycle consume strobe to the receiver.
REQ-010 tx_done  input  1  transmitter completion level; set on stop bit, cleared by trmt.
REQ-011 trmt  output  1  one-cycle transmit-start strobe.
REQ-012 tx_data  output  8  byte to transmit; stable from the trmt cycle until tx_done.
REQ-013 cmd  output  24  assembled frame {opcode, data_hi, data_lo}.
REQ-014 cmd_rdy  output  1  level; frame in cmd is valid.
REQ-015 clr_cmd_rdy  input  1  consumer acknowledges cmd.
REQ-016 frame_err  output  1  one-cycle pulse on frame timeout.

Function
REQ-017 States SHALL be IDLE, GET_HI, GET_LO, HOLD, SEND, WAIT_TX.
REQ-018 IDLE: rx_rdy=1 -> latch cmd[23:16]=rx_data, assert clr_rx_rdy that cycle, clear timer, go to GET_HI.
REQ-019 GET_HI: rx_rdy=1 -> latch cmd[15:8], assert clr_rx_rdy, clear timer, go to GET_LO.
REQ-020 GET_LO: rx_rdy=1 -> latch cmd[7:0], assert clr_rx_rdy, go to HOLD; cmd_rdy=1 starting the next cycle.
REQ-021 clr_rx_rdy SHALL be combinational: IDLE/GET_HI/GET_LO and rx_rdy=1; never asserted in HOLD, SEND or WAIT_TX.
REQ-022 Timer: 16 bits, counts every cycle in GET_HI/GET_LO, held at 0 elsewhere.
REQ-023 Timeout: in GET_HI/GET_LO with TIMEOUT_CYC!=0, timer==TIMEOUT_CYC-1 and rx_rdy=0 -> pulse frame_err next cycle, load tx_data=NAK_BYTE, go to SEND; partial cmd bits retained but cmd_rdy stays 0.
REQ-024 rx_rdy=1 in the same cycle as timeout: the byte wins; no frame_err.
REQ-025 HOLD: cmd_rdy=1, cmd stable; incoming bytes are not consumed (the receiver may overwrite them).
REQ-026 HOLD with clr_cmd_rdy=1 -> cmd_rdy=0 next cycle, load tx_data=ACK_BYTE, go to SEND.
REQ-027 clr_cmd_rdy outside HOLD SHALL be ignored.
REQ-028 SEND: trmt=1 for exactly one cycle, then go to WAIT_TX unconditionally.
REQ-029 WAIT_TX: tx_done=1 -> go to IDLE; tx_done is first sampled the cycle after trmt.
REQ-030 Bytes arriving during SEND/WAIT_TX are left pending; IDLE consumes the pending byte on its first cycle.
REQ-031 Frame-to-frame throughput: at most one frame per response; no frame is accepted before the response completes.

Reset
REQ-032 While rst=1 for one or more cycles: state=IDLE, timer=0, cmd=24'h0, tx_data=8'h00, cmd_rdy=0, trmt=0, frame_err=0, clr_rx_rdy=0.
REQ-033 rst mid-frame or mid-response SHALL abort without any further trmt or frame_err; a transmission already in flight is not tracked.

Structure
REQ-034 Package uart_cmd_pkg SHALL hold the state enum and the default ACK_BYTE/NAK_BYTE constants.
REQ-035 The timeout counter SHALL be one sub-module, frame_timer (inputs: en, clr; output: expired).
REQ-036 The datapath SHALL be a 24-bit capture register, an 8-bit tx_data register and the FSM; no FIFO.

Verification
REQ-037 Bytes 8'h12, 8'h34, 8'h56, each rx_rdy until clr_rx_rdy -> cmd=24'h123456, cmd_rdy=1 one cycle after the third clr_rx_rdy.
REQ-038 clr_cmd_rdy pulse in HOLD -> cmd_rdy=0, one trmt with tx_data=8'hA5; tx_done after 10 cycles -> back in IDLE.
REQ-039 TIMEOUT_CYC=100: one byte then silence -> frame_err exactly 100 cycles after the GET_HI entry, trmt with tx_data=8'hEE, cmd_rdy never 1.
REQ-040 rx_rdy asserted on the exact timeout cycle -> byte accepted, no frame_err, frame completes normally.
REQ-041 rst pulsed in GET_LO -> all outputs 0 the next cycle; a fresh 3-byte frame is then assembled correctly.
REQ-042 Byte arrives during WAIT_TX -> not consumed until IDLE; clr_rx_rdy in the first IDLE cycle.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and default response bytes
// for the UART command controller.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_HI  = 3'd1,
    GET_LO  = 3'd2,
    HOLD    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  localparam logic [7:0] ACK_DEF = 8'hA5;
  localparam logic [7:0] NAK_DEF = 8'hEE;

endpackage

// File: rtl/uart_cmd_ctrl_frame_timer.sv
// Inter-byte timeout counter; LIMIT of 0
// disables expiry.
module frame_timer #(
  parameter logic [15:0] LIMIT = 16'd52080
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  logic [15:0] cnt;

  // count while enabled, sit at zero otherwise
  always_ff @(posedge clk) begin
    if (rst || clr || !en)
      cnt <= '0;
    else
      cnt <= cnt + 16'd1;
  end

  assign expired = (LIMIT != 16'd0) && en &&
                   (cnt == LIMIT - 16'd1);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Assembles 3-byte command frames from a UART
// receiver and answers each with ACK or NAK.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = 16'd52080,
  parameter logic [7:0]  ACK_BYTE    = ACK_DEF,
  parameter logic [7:0]  NAK_BYTE    = NAK_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  input  logic        tx_done,
  output logic        trmt,
  output logic [7:0]  tx_data,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frame_err
);

  state_t state;
  state_t state_nxt;
  logic   timing;
  logic   take;
  logic   expired;
  logic   tout;
  logic   ack;
  logic   err_q;

  assign timing = (state == GET_HI) ||
                  (state == GET_LO);
  assign take   = rx_rdy &&
                  (timing || state == IDLE);
  assign tout   = expired && !rx_rdy;
  assign ack    = (state == HOLD) && clr_cmd_rdy;

  frame_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (timing),
    .clr     (take),
    .expired (expired)
  );

  // frame / response sequencing
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (rx_rdy) state_nxt = GET_HI;
      GET_HI:
        if (rx_rdy)    state_nxt = GET_LO;
        else if (tout) state_nxt = SEND;
      GET_LO:
        if (rx_rdy)    state_nxt = HOLD;
        else if (tout) state_nxt = SEND;
      HOLD:
        if (clr_cmd_rdy) state_nxt = SEND;
      SEND:
        state_nxt = WAIT_TX;
      WAIT_TX:
        if (tx_done) state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // capture bytes into their frame slot
  always_ff @(posedge clk) begin
    if (rst)
      cmd <= '0;
    else if (take)
      case (state)
        IDLE:    cmd[23:16] <= rx_data;
        GET_HI:  cmd[15:8]  <= rx_data;
        default: cmd[7:0]   <= rx_data;
      endcase
  end

  // response byte and timeout pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= tout;
      if (tout)     tx_data <= NAK_BYTE;
      else if (ack) tx_data <= ACK_BYTE;
    end
  end

  // strobes are forced low during reset
  assign clr_rx_rdy = take && !rst;
  assign trmt       = (state == SEND) && !rst;
  assign cmd_rdy    = (state == HOLD) && !rst;
  assign frame_err  = err_q && !rst;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl with a
// receiver/transmitter model and frame reference.
module tb_uart_cmd_ctrl;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rx_rdy;
  logic        tx_done = 1'b0;
  logic        trmt;
  logic [7:0]  tx_data;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        frame_err;

  int n_chk = 0;
  int n_fail = 0;
  int tx_cnt = 0;
  logic [7:0] tx_q [$];

  always #5 clk = ~clk;

  uart_cmd_ctrl #(
    .TIMEOUT_CYC (16'd100),
    .ACK_BYTE    (8'hA5),
    .NAK_BYTE    (8'hEE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .tx_done     (tx_done),
    .trmt        (trmt),
    .tx_data     (tx_data),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .frame_err   (frame_err)
  );

  // transmitter: records bytes, done 10 cycles later
  always @(posedge clk) begin
    if (trmt === 1'b1) begin
      tx_q.push_back(tx_data);
      tx_cnt  <= 10;
      tx_done <= 1'b0;
    end else if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_done <= 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_rdy = 1'b0;
    clr_cmd_rdy = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    tx_q.delete();
  endtask

  // present a byte until consumed; lat=-1 if never
  task automatic send_byte(input logic [7:0] b,
                           output int lat);
    lat = -1;
    rx_data = b;
    rx_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (clr_rx_rdy === 1'b1) begin
        lat = i;
        break;
      end
      step();
    end
    step();
    rx_rdy = 1'b0;
  endtask

  // wait for tx_done, then one more cycle to IDLE
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (tx_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_rdy = 1'b0;
    repeat (2) step();
    rx_rdy = 1'b1;
    #1;
    n_chk++;
    if (cmd !== 24'h0 || tx_data !== 8'h00 ||
        cmd_rdy !== 1'b0 || trmt !== 1'b0 ||
        frame_err !== 1'b0 || clr_rx_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outs got cmd=%h tx=%h r=%b t=%b e=%b c=%b exp all 0",
               cmd, tx_data, cmd_rdy, trmt, frame_err, clr_rx_rdy);
    end
    rx_rdy = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_frame();
    int l0, l1, l2, bad;
    bit ok;
    do_reset();
    send_byte(8'h12, l0);
    send_byte(8'h34, l1);
    n_chk++;
    if (cmd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_early_rdy got %b exp 0", cmd_rdy);
    end
    send_byte(8'h56, l2);
    n_chk++;
    if (l0 != 0 || l1 != 0 || l2 != 0) begin
      n_fail++;
      $display("FAIL frame_lat got %0d %0d %0d exp 0 0 0",
               l0, l1, l2);
    end
    n_chk++;
    if (cmd_rdy !== 1'b1 || cmd !== 24'h123456) begin
      n_fail++;
      $display("FAIL frame_cmd got %b/%h exp 1/123456",
               cmd_rdy, cmd);
    end
    bad = 0;
    rx_data = 8'h77;
    rx_rdy = 1'b1;
    repeat (3) begin
      #1;
      if (clr_rx_rdy !== 1'b0 || cmd_rdy !== 1'b1) bad++;
      step();
    end
    rx_rdy = 1'b0;
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold_no_consume got %0d bad exp 0", bad);
    end
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    n_chk++;
    if (cmd_rdy !== 1'b0 || trmt !== 1'b1 ||
        tx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL ack_send got r=%b t=%b d=%h exp 0/1/a5",
               cmd_rdy, trmt, tx_data);
    end
    step();
    wait_done(ok);
    rx_data = 8'h9A;
    rx_rdy = 1'b1;
    #1;
    n_chk++;
    if (!ok || clr_rx_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_idle got ok=%b clr=%b exp 1/1",
               ok, clr_rx_rdy);
    end
    rx_rdy = 1'b0;
    n_chk++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'hA5) begin
      n_fail++;
      $display("FAIL ack_bytes got n=%0d exp 1 x a5",
               tx_q.size());
    end
  endtask

  task automatic test_timeout();
    int l, k;
    bit seen, ok;
    do_reset();
    send_byte(8'hAB, l);
    k = 0;
    seen = 1'b0;
    while (frame_err !== 1'b1 && k < 200) begin
      if (cmd_rdy === 1'b1) seen = 1'b1;
      step();
      k++;
    end
    n_chk++;
    if (k != TO) begin
      n_fail++;
      $display("FAIL tout_latency got %0d exp %0d", k, TO);
    end
    n_chk++;
    if (trmt !== 1'b1 || tx_data !== 8'hEE ||
        cmd[23:16] !== 8'hAB) begin
      n_fail++;
      $display("FAIL tout_nak got t=%b d=%h c=%h exp 1/ee/ab",
               trmt, tx_data, cmd[23:16]);
    end
    step();
    n_chk++;
    if (frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL tout_pulse got %b exp 0", frame_err);
    end
    wait_done(ok);
    n_chk++;
    if (!ok || seen || tx_q.size() != 1 ||
        tx_q[0] !== 8'hEE) begin
      n_fail++;
      $display("FAIL tout_resp got ok=%b rdy=%b n=%0d exp 1/0/1",
               ok, seen, tx_q.size());
    end
  endtask

  task automatic test_timeout_edge();
    int l1, l2, l3;
    bit err;
    do_reset();
    err = 1'b0;
    send_byte(8'h01, l1);
    repeat (TO - 1) begin
      if (frame_err === 1'b1) err = 1'b1;
      step();
    end
    send_byte(8'h02, l2);
    repeat (TO - 1) begin
      if (frame_err === 1'b1) err = 1'b1;
      step();
    end
    send_byte(8'h03, l3);
    repeat (3) begin
      if (frame_err === 1'b1) err = 1'b1;
      step();
    end
    n_chk++;
    if (l2 != 0 || l3 != 0 || err) begin
      n_fail++;
      $display("FAIL edge_accept got l=%0d/%0d err=%b exp 0/0/0",
               l2, l3, err);
    end
    n_chk++;
    if (cmd_rdy !== 1'b1 || cmd !== 24'h010203) begin
      n_fail++;
      $display("FAIL edge_cmd got %b/%h exp 1/010203",
               cmd_rdy, cmd);
    end
  endtask

  task automatic test_reset_mid();
    int l, bad;
    do_reset();
    send_byte(8'h11, l);
    send_byte(8'h22, l);
    rst = 1'b1;
    step();
    n_chk++;
    if (cmd !== 24'h0 || tx_data !== 8'h00 ||
        cmd_rdy !== 1'b0 || trmt !== 1'b0 ||
        frame_err !== 1'b0 || clr_rx_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outs got cmd=%h tx=%h exp 0",
               cmd, tx_data);
    end
    rst = 1'b0;
    bad = 0;
    repeat (TO + 50) begin
      if (trmt === 1'b1 || frame_err === 1'b1) bad++;
      step();
    end
    n_chk++;
    if (bad != 0 || tx_q.size() != 0) begin
      n_fail++;
      $display("FAIL midrst_quiet got %0d/%0d exp 0/0",
               bad, tx_q.size());
    end
    send_byte(8'h33, l);
    send_byte(8'h44, l);
    send_byte(8'h55, l);
    n_chk++;
    if (cmd_rdy !== 1'b1 || cmd !== 24'h334455) begin
      n_fail++;
      $display("FAIL midrst_frame got %b/%h exp 1/334455",
               cmd_rdy, cmd);
    end
  endtask

  task automatic test_pending();
    int l, bad;
    bit ok;
    do_reset();
    send_byte(8'h0A, l);
    send_byte(8'h0B, l);
    send_byte(8'h0C, l);
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    step();
    rx_data = 8'h5A;
    rx_rdy = 1'b1;
    bad = 0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (clr_rx_rdy !== 1'b0) bad++;
      if (tx_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    n_chk++;
    if (bad != 0 || !ok) begin
      n_fail++;
      $display("FAIL pend_held got bad=%0d ok=%b exp 0/1",
               bad, ok);
    end
    step();
    n_chk++;
    if (clr_rx_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_idle got %b exp 1", clr_rx_rdy);
    end
    step();
    rx_rdy = 1'b0;
    n_chk++;
    if (cmd[23:16] !== 8'h5A) begin
      n_fail++;
      $display("FAIL pend_byte got %h exp 5a", cmd[23:16]);
    end
  endtask

  task automatic test_random();
    logic [7:0] b [3];
    int gap [3];
    int l, k, hold, r;
    bit nak, err, rdy, ok, aborted;
    logic [7:0] exp_b;
    do_reset();
    for (int f = 0; f < 25; f++) begin
      for (int j = 0; j < 3; j++) begin
        b[j] = 8'($urandom);
        r = int'($urandom_range(0, 9));
        if (r < 6)       gap[j] = int'($urandom_range(0, 30));
        else if (r == 6) gap[j] = TO - 1;
        else if (r == 7) gap[j] = TO - 2;
        else             gap[j] = TO + int'($urandom_range(0, 5));
      end
      nak = (gap[1] >= TO) || (gap[2] >= TO);
      exp_b = nak ? 8'hEE : 8'hA5;
      err = 1'b0;
      rdy = 1'b0;
      aborted = 1'b0;
      tx_q.delete();
      send_byte(b[0], l);
      for (int j = 1; j < 3 && !aborted; j++) begin
        if (gap[j] < TO) begin
          repeat (gap[j]) begin
            if (frame_err === 1'b1) err = 1'b1;
            if (cmd_rdy === 1'b1) rdy = 1'b1;
            clr_cmd_rdy = ($urandom_range(0, 3) == 0);
            step();
          end
          clr_cmd_rdy = 1'b0;
          send_byte(b[j], l);
          if (l != 0) err = 1'b1;
        end else begin
          k = 0;
          while (frame_err !== 1'b1 && k < 200) begin
            if (cmd_rdy === 1'b1) rdy = 1'b1;
            step();
            k++;
          end
          n_chk++;
          if (k != TO || rdy) begin
            n_fail++;
            $display("FAIL rnd_tout f=%0d got %0d rdy=%b exp %0d/0",
                     f, k, rdy, TO);
          end
          aborted = 1'b1;
        end
      end
      if (!nak) begin
        n_chk++;
        if (err || rdy || cmd_rdy !== 1'b1 ||
            cmd !== {b[0], b[1], b[2]}) begin
          n_fail++;
          $display("FAIL rnd_cmd f=%0d got %b/%h exp 1/%h",
                   f, cmd_rdy, cmd, {b[0], b[1], b[2]});
        end
        hold = int'($urandom_range(0, 4));
        repeat (hold) begin
          if (cmd_rdy !== 1'b1 ||
              cmd !== {b[0], b[1], b[2]}) err = 1'b1;
          step();
        end
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
      end
      step();
      wait_done(ok);
      n_chk++;
      if (!ok || err || tx_q.size() != 1 ||
          tx_q[0] !== exp_b) begin
        n_fail++;
        $display("FAIL rnd_resp f=%0d ok=%b err=%b n=%0d exp byte %h",
                 f, ok, err, tx_q.size(), exp_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    test_pending();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
